// File: rtl/match_pkg.sv
// Shared types for the Pong match controller.
// State encodings double as the debug/display code on state_o.
package match_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        SERVE     = 3'd1,
        PLAY      = 3'd2,
        PAUSED    = 3'd3,
        POINT     = 3'd4,
        GAME_WON  = 3'd5,
        GAME_OVER = 3'd6
    } match_state_t;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/phase_timer.sv
// Phase timer: counts enabled cycles since the last clear.
// done is registered and goes high once the count equals limit.
module phase_timer #(
    parameter int W = 26
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clear,
    input  logic         enable,
    input  logic [W-1:0] limit,
    output logic         done
);

    logic [W-1:0] cnt_q, cnt_d;
    logic         done_q, done_d;

    always_comb begin
        cnt_d  = cnt_q;
        done_d = done_q;
        if (clear) begin
            cnt_d  = '0;
            done_d = (limit == '0);
        end else if (enable) begin
            cnt_d  = cnt_q + W'(1);
            done_d = ((cnt_q + W'(1)) == limit);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q  <= '0;
            done_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            done_q <= done_d;
        end
    end

    assign done = done_q;

endmodule

// File: rtl/match_controller.sv
// Pong match sequencer: serve, rally, point, pause, game win,
// level advance and match end, with registered strobes and buses.
module match_controller
    import match_pkg::*;
#(
    parameter int WIN_SCORE    = 7,
    parameter int SCORE_W      = 3,
    parameter int MAX_LEVEL    = 7,
    parameter int LEVEL_W      = 3,
    parameter int SERVE_CYCLES = 50_000_000,
    parameter int POINT_CYCLES = 25_000_000
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               run_en,
    input  logic               p1_point,
    input  logic               p2_point,
    output logic               game_on,
    output logic               round_rst_n,
    output logic [SCORE_W-1:0] p1_total,
    output logic [SCORE_W-1:0] p2_total,
    output logic [LEVEL_W-1:0] level,
    output logic               lvl_up,
    output logic               win,
    output logic               winner,
    output logic               match_over,
    output logic [2:0]         state_o
);

    localparam int TW = max_int($clog2(max_int(SERVE_CYCLES, POINT_CYCLES)), 1);
    localparam logic [TW-1:0]      SERVE_LIM = TW'(SERVE_CYCLES - 1);
    localparam logic [TW-1:0]      POINT_LIM = TW'(POINT_CYCLES - 1);
    localparam logic [SCORE_W-1:0] WIN       = SCORE_W'(WIN_SCORE);
    localparam logic [LEVEL_W-1:0] MAX_LVL   = LEVEL_W'(MAX_LEVEL);
    localparam logic [LEVEL_W-1:0] LVL_ONE   = LEVEL_W'(1);

    match_state_t       state_q, state_d;
    logic [SCORE_W-1:0] p1_q, p1_d, p2_q, p2_d;
    logic [LEVEL_W-1:0] level_q, level_d;
    logic game_on_q, game_on_d, round_rst_n_q, round_rst_n_d;
    logic lvl_up_q, lvl_up_d, win_q, win_d;
    logic winner_q, winner_d, match_over_q, match_over_d;

    logic          t_clear, t_en, t_done;
    logic [TW-1:0] t_limit;

    always_comb begin
        state_d  = state_q;
        p1_d     = p1_q;
        p2_d     = p2_q;
        level_d  = level_q;
        winner_d = winner_q;
        lvl_up_d = 1'b0;
        unique case (state_q)
            IDLE: if (start) state_d = SERVE;
            SERVE: if (run_en && t_done) state_d = PLAY;
            PLAY: begin
                // Pause wins over any point sampled in the same cycle.
                if (!run_en) begin
                    state_d = PAUSED;
                end else if (p1_point && p2_point) begin
                    state_d = SERVE;
                end else if (p1_point) begin
                    if (p1_q != WIN) p1_d = p1_q + SCORE_W'(1);
                    state_d = POINT;
                end else if (p2_point) begin
                    if (p2_q != WIN) p2_d = p2_q + SCORE_W'(1);
                    state_d = POINT;
                end
            end
            PAUSED: if (run_en) state_d = PLAY;
            POINT: begin
                if (t_done) begin
                    if (p1_q == WIN || p2_q == WIN) begin
                        state_d  = GAME_WON;
                        winner_d = (p1_q != WIN);
                    end else begin
                        state_d = SERVE;
                    end
                end
            end
            GAME_WON: begin
                if (level_q < MAX_LVL) begin
                    level_d  = level_q + LEVEL_W'(1);
                    lvl_up_d = 1'b1;
                    p1_d     = '0;
                    p2_d     = '0;
                    state_d  = SERVE;
                end else begin
                    state_d = GAME_OVER;
                end
            end
            GAME_OVER: begin
                if (start) begin
                    level_d = LVL_ONE;
                    p1_d    = '0;
                    p2_d    = '0;
                    state_d = SERVE;
                end
            end
            default: state_d = IDLE;
        endcase
        game_on_d     = (state_d == PLAY);
        win_d         = (state_d == GAME_WON);
        match_over_d  = (state_d == GAME_OVER);
        round_rst_n_d = !(state_d == SERVE && state_q != SERVE);
    end

    // Limit follows the next state so done is ready right after entry.
    assign t_clear = (state_d != state_q);
    assign t_en    = (state_q == SERVE && run_en) || (state_q == POINT);
    assign t_limit = (state_d == POINT) ? POINT_LIM : SERVE_LIM;

    phase_timer #(.W(TW)) u_timer (
        .clk    (clk),
        .reset  (reset),
        .clear  (t_clear),
        .enable (t_en),
        .limit  (t_limit),
        .done   (t_done)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= IDLE;
            p1_q          <= '0;
            p2_q          <= '0;
            level_q       <= LVL_ONE;
            game_on_q     <= 1'b0;
            round_rst_n_q <= 1'b1;
            lvl_up_q      <= 1'b0;
            win_q         <= 1'b0;
            winner_q      <= 1'b0;
            match_over_q  <= 1'b0;
        end else begin
            state_q       <= state_d;
            p1_q          <= p1_d;
            p2_q          <= p2_d;
            level_q       <= level_d;
            game_on_q     <= game_on_d;
            round_rst_n_q <= round_rst_n_d;
            lvl_up_q      <= lvl_up_d;
            win_q         <= win_d;
            winner_q      <= winner_d;
            match_over_q  <= match_over_d;
        end
    end

    assign state_o     = state_q;
    assign game_on     = game_on_q;
    assign round_rst_n = round_rst_n_q;
    assign p1_total    = p1_q;
    assign p2_total    = p2_q;
    assign level       = level_q;
    assign lvl_up      = lvl_up_q;
    assign win         = win_q;
    assign winner      = winner_q;
    assign match_over  = match_over_q;

endmodule

// File: tb/tb_match_controller.sv
// Bench for match_controller: directed opening, then random play
// compared every cycle against a behavioural match model.
module tb_match_controller;

    localparam int WS = 3;
    localparam int SW = 3;
    localparam int ML = 2;
    localparam int LW = 3;
    localparam int SC = 4;
    localparam int PC = 3;

    localparam int S_IDLE = 0, S_SERVE = 1, S_PLAY = 2, S_PAUSED = 3;
    localparam int S_POINT = 4, S_WON = 5, S_OVER = 6;

    logic          clk = 1'b0;
    logic          reset;
    logic          start, run_en, p1_point, p2_point;
    logic          game_on, round_rst_n, lvl_up, win, winner, match_over;
    logic [SW-1:0] p1_total, p2_total;
    logic [LW-1:0] level;
    logic [2:0]    state_o;

    match_controller #(
        .WIN_SCORE(WS), .SCORE_W(SW), .MAX_LEVEL(ML), .LEVEL_W(LW),
        .SERVE_CYCLES(SC), .POINT_CYCLES(PC)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .run_en(run_en),
        .p1_point(p1_point), .p2_point(p2_point),
        .game_on(game_on), .round_rst_n(round_rst_n),
        .p1_total(p1_total), .p2_total(p2_total), .level(level),
        .lvl_up(lvl_up), .win(win), .winner(winner),
        .match_over(match_over), .state_o(state_o)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_pass = 0;

    // behavioural model of the match
    int m_st, m_cnt, m_p1, m_p2, m_lvl;
    int m_gon, m_rr, m_win, m_winner, m_lvlup, m_mo;
    int games_won = 0;

    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    endtask

    task automatic model_reset();
        m_st = S_IDLE; m_cnt = 0; m_p1 = 0; m_p2 = 0; m_lvl = 1;
        m_gon = 0; m_rr = 1; m_win = 0; m_winner = 0; m_lvlup = 0; m_mo = 0;
    endtask

    task automatic model_step(input bit s, input bit r, input bit a, input bit b);
        int nst;
        nst = m_st;
        m_lvlup = 0;
        case (m_st)
            S_IDLE: if (s) nst = S_SERVE;
            S_SERVE: if (r) begin
                m_cnt++;
                if (m_cnt == SC) nst = S_PLAY;
            end
            S_PLAY: begin
                if (!r) nst = S_PAUSED;
                else if (a && b) nst = S_SERVE;
                else if (a) begin m_p1 = (m_p1 < WS) ? m_p1 + 1 : WS; nst = S_POINT; end
                else if (b) begin m_p2 = (m_p2 < WS) ? m_p2 + 1 : WS; nst = S_POINT; end
            end
            S_PAUSED: if (r) nst = S_PLAY;
            S_POINT: begin
                m_cnt++;
                if (m_cnt == PC) begin
                    if (m_p1 == WS || m_p2 == WS) begin
                        nst = S_WON;
                        m_winner = (m_p2 == WS) ? 1 : 0;
                        games_won++;
                    end else nst = S_SERVE;
                end
            end
            S_WON: begin
                if (m_lvl < ML) begin
                    m_lvl++; m_lvlup = 1; m_p1 = 0; m_p2 = 0; nst = S_SERVE;
                end else nst = S_OVER;
            end
            S_OVER: if (s) begin
                m_lvl = 1; m_p1 = 0; m_p2 = 0; nst = S_SERVE;
            end
            default: nst = S_IDLE;
        endcase
        m_rr = (nst == S_SERVE && m_st != S_SERVE) ? 0 : 1;
        if (nst != m_st) m_cnt = 0;
        m_st  = nst;
        m_gon = (m_st == S_PLAY);
        m_win = (m_st == S_WON);
        m_mo  = (m_st == S_OVER);
    endtask

    task automatic compare_all();
        chk("state", state_o, m_st);
        chk("game_on", game_on, m_gon);
        chk("round_rst_n", round_rst_n, m_rr);
        chk("p1_total", p1_total, m_p1);
        chk("p2_total", p2_total, m_p2);
        chk("level", level, m_lvl);
        chk("lvl_up", lvl_up, m_lvlup);
        chk("win", win, m_win);
        chk("winner", winner, m_winner);
        chk("match_over", match_over, m_mo);
    endtask

    task automatic cyc(input bit s, input bit r, input bit a, input bit b);
        start = s; run_en = r; p1_point = a; p2_point = b;
        @(posedge clk);
        model_step(s, r, a, b);
        @(negedge clk);
        compare_all();
    endtask

    task automatic async_reset();
        reset = 1'b0;
        #1;
        model_reset();
        compare_all();
        @(negedge clk);
        reset = 1'b1;
    endtask

    initial begin
        reset = 1'b0; start = 0; run_en = 0; p1_point = 0; p2_point = 0;
        model_reset();
        repeat (2) @(negedge clk);
        compare_all();
        reset = 1'b1;
        cyc(0, 1, 0, 0);
        cyc(1, 1, 0, 0);
        chk("serve_rr_low", round_rst_n, 0);
        for (int i = 0; i < 4; i++) cyc(0, 1, 0, 0);
        chk("play_after_4", game_on, 1);
        cyc(0, 1, 0, 1);
        chk("p2_scored", p2_total, 1);
        for (int i = 0; i < 3; i++) cyc(0, 1, 0, 0);
        chk("reserve_rr", round_rst_n, 0);
        for (int i = 0; i < 4; i++) cyc(0, 1, 0, 0);
        cyc(0, 0, 1, 0);
        chk("pause_drop", p1_total, 0);
        for (int i = 0; i < 20; i++) cyc(0, 0, (i == 9), 0);
        cyc(0, 1, 0, 0);
        chk("resume", game_on, 1);
        cyc(0, 1, 1, 1);
        chk("both_reserve", state_o, S_SERVE);
        cyc(0, 1, 0, 0);
        async_reset();
        chk("rst_mid_serve", state_o, S_IDLE);
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 599) == 0) begin
                async_reset();
            end else begin
                cyc($urandom_range(0, 3) == 0, $urandom_range(0, 7) != 0,
                    $urandom_range(0, 2) == 0, $urandom_range(0, 2) == 0);
            end
        end
        chk("games_seen", int'(games_won > 2), 1);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
